// File: rtl/phv_rx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phv_rx_fifo_if : PHV hand-off bundle (last stage -> rx fifo -> deparser)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface phv_rx_fifo_if #(
  parameter int PHV_LEN = 1024
);
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic               phv_fifo_ready;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_out_valid;
  logic               phv_out_ready;

  // Master is the environment around the fifo: upstream stage plus deparser.
  modport master (
    output phv_in, phv_in_valid, phv_out_ready,
    input  phv_fifo_ready, phv_out, phv_out_valid
  );

  modport slave (
    input  phv_in, phv_in_valid, phv_out_ready,
    output phv_fifo_ready, phv_out, phv_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/phv_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phv_rx_fifo : FWFT receive buffer for PHVs from the final pipeline stage,  |
// |   early ready deassertion to absorb in-flight PHVs.                        |
// |   Optional macro PHV_RX_DROP_CNT_EN builds the saturating drop counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phv_rx_fifo #(
  parameter int PHV_LEN      = 1024,
  parameter int DEPTH_LOG2   = 4,
  parameter int READY_MARGIN = 3
) (
  input  wire logic                  axis_clk,
  input  wire logic                  aresetn,
  phv_rx_fifo_if.slave               phv_if,
  output logic [DEPTH_LOG2:0]        fifo_count,
  output logic                       overflow,
  output logic [31:0]                drop_cnt
);

  localparam int                  DEPTH       = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL      = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_READY_LIM = (DEPTH_LOG2+1)'(DEPTH - READY_MARGIN);

  logic [PHV_LEN-1:0]    mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == C_FULL);

  // A full buffer still accepts a PHV when the head leaves in the same cycle.
  always_comb begin
    pop  = !empty && phv_if.phv_out_ready;
    push = phv_if.phv_in_valid && (!full || pop);
    drop = phv_if.phv_in_valid && full && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase

    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr_q] <= phv_if.phv_in;
  end

`ifdef PHV_RX_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign phv_if.phv_out_valid  = !empty;
  assign phv_if.phv_out        = empty ? '0 : mem[rd_ptr_q];
  assign phv_if.phv_fifo_ready = (count_q < C_READY_LIM);
  assign fifo_count            = count_q;
  assign overflow              = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_phv_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_phv_rx_fifo : randomized bench for phv_rx_fifo with a queue model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_phv_rx_fifo;

  localparam int PHV_LEN      = 1024;
  localparam int DEPTH_LOG2   = 4;
  localparam int DEPTH        = 16;
  localparam int READY_MARGIN = 3;

  logic                axis_clk = 1'b0;
  logic                aresetn  = 1'b0;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;
  logic [31:0]         drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [PHV_LEN-1:0] mq[$];
  bit                 m_ovf   = 1'b0;
  int unsigned        m_drops = 0;

  phv_rx_fifo_if #(.PHV_LEN(PHV_LEN)) phv_if ();

  phv_rx_fifo #(
    .PHV_LEN     (PHV_LEN),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .READY_MARGIN(READY_MARGIN)
  ) dut (
    .axis_clk  (axis_clk),
    .aresetn   (aresetn),
    .phv_if    (phv_if.slave),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic logic [PHV_LEN-1:0] rnd_phv();
    logic [PHV_LEN-1:0] v;
    for (int i = 0; i < PHV_LEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] exp_drops();
`ifdef PHV_RX_DROP_CNT_EN
    return m_drops;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic exp_ready();
    return (mq.size() < DEPTH - READY_MARGIN);
  endfunction

  function automatic logic [PHV_LEN-1:0] exp_head();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  // Drive one cycle of inputs, then advance the model across the clock edge.
  task automatic cyc(input bit v, input logic [PHV_LEN-1:0] d, input bit r);
    bit pop;
    bit full;
    phv_if.phv_in_valid  = v;
    phv_if.phv_in        = d;
    phv_if.phv_out_ready = r;
    @(posedge axis_clk);
    #1;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && r;
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (!full || pop) mq.push_back(d);
      else begin
        m_ovf = 1'b1;
        m_drops++;
      end
    end
    phv_if.phv_in_valid  = 1'b0;
    phv_if.phv_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic test_reset();
    phv_if.phv_in        = '0;
    phv_if.phv_in_valid  = 1'b0;
    phv_if.phv_out_ready = 1'b0;
    aresetn              = 1'b0;
    #2;
    checks++;
    if (fifo_count !== 5'd0 || phv_if.phv_out_valid !== 1'b0 || phv_if.phv_fifo_ready !== 1'b1 ||
        overflow !== 1'b0 || drop_cnt !== 32'd0 || phv_if.phv_out !== '0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b ready=%b ovf=%b drop=%0d (need 0 0 1 0 0)",
               fifo_count, phv_if.phv_out_valid, phv_if.phv_fifo_ready, overflow, drop_cnt);
    end
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_in_order();
    logic [PHV_LEN-1:0] v;
    for (int k = 1; k <= 5; k++) begin
      v = PHV_LEN'(k);
      cyc(1'b1, v, 1'b1);
      checks++;
      if (phv_if.phv_out !== v || phv_if.phv_out_valid !== 1'b1 || fifo_count !== 5'd1 ||
          phv_if.phv_fifo_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_order[%0d]: out=%0h valid=%b count=%0d ready=%b (need %0d 1 1 1)",
                 k, phv_if.phv_out[63:0], phv_if.phv_out_valid, fifo_count, phv_if.phv_fifo_ready, k);
      end
    end
    cyc(1'b0, '0, 1'b1);
    checks++;
    if (fifo_count !== 5'd0 || phv_if.phv_out_valid !== 1'b0 || phv_if.phv_out !== '0) begin
      errors++;
      $display("FAIL in_order_empty: count=%0d valid=%b (need 0 0)", fifo_count, phv_if.phv_out_valid);
    end
  endtask

  task automatic test_ready_threshold();
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, rnd_phv(), 1'b0);
      checks++;
      if (fifo_count !== 5'(k) || phv_if.phv_fifo_ready !== (k < 13) || overflow !== 1'b0) begin
        errors++;
        $display("FAIL ready_threshold[%0d]: count=%0d ready=%b ovf=%b (need %0d %b 0)",
                 k, fifo_count, phv_if.phv_fifo_ready, overflow, k, (k < 13));
      end
    end
  endtask

  task automatic test_overflow();
    cyc(1'b1, rnd_phv(), 1'b0);
    checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== exp_drops()) begin
      errors++;
      $display("FAIL overflow: count=%0d ovf=%b drop=%0d (need 16 1 %0d)",
               fifo_count, overflow, drop_cnt, exp_drops());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (phv_if.phv_out !== exp_head() || phv_if.phv_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: out=%0h valid=%b need=%0h",
                 i, phv_if.phv_out[63:0], phv_if.phv_out_valid, exp_head() & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      cyc(1'b0, '0, 1'b1);
    end
    checks++;
    if (fifo_count !== 5'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after_drain: count=%0d ovf=%b (need 0 1)", fifo_count, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [PHV_LEN-1:0] x;
    do_reset();
    for (int k = 0; k < 16; k++) cyc(1'b1, rnd_phv(), 1'b0);
    x = rnd_phv();
    cyc(1'b1, x, 1'b1);
    checks++;
    if (fifo_count !== 5'd16 || overflow !== 1'b0 || drop_cnt !== 32'd0) begin
      errors++;
      $display("FAIL full_push_pop: count=%0d ovf=%b drop=%0d (need 16 0 0)", fifo_count, overflow, drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (phv_if.phv_out !== exp_head() || (i == 15 && phv_if.phv_out !== x)) begin
        errors++;
        $display("FAIL full_push_pop_drain[%0d]: out=%0h need=%0h",
                 i, phv_if.phv_out[63:0], exp_head() & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      cyc(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_random();
    int attempts = 0;
    int cycles   = 0;
    bit v;
    bit r;
    while (attempts < 40 && cycles < 400) begin
      v = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1);
      if (v) attempts++;
      cyc(v, rnd_phv(), r);
      cycles++;
      checks++;
      if (fifo_count !== 5'(mq.size()) || phv_if.phv_out_valid !== (mq.size() != 0) ||
          phv_if.phv_out !== exp_head() || phv_if.phv_fifo_ready !== exp_ready() ||
          overflow !== m_ovf || drop_cnt !== exp_drops()) begin
        errors++;
        $display("FAIL random[%0d]: count=%0d/%0d valid=%b ready=%b/%b ovf=%b/%b drop=%0d/%0d out=%0h need=%0h",
                 cycles, fifo_count, mq.size(), phv_if.phv_out_valid, phv_if.phv_fifo_ready, exp_ready(),
                 overflow, m_ovf, drop_cnt, exp_drops(), phv_if.phv_out[63:0],
                 exp_head() & 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    checks++;
    if (attempts < 40) begin
      errors++;
      $display("FAIL random_budget: attempts=%0d need=40", attempts);
    end
    for (int i = 0; i < 40 && mq.size() != 0; i++) begin
      checks++;
      if (phv_if.phv_out !== exp_head()) begin
        errors++;
        $display("FAIL random_drain[%0d]: out=%0h need=%0h",
                 i, phv_if.phv_out[63:0], exp_head() & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      cyc(1'b0, '0, 1'b1);
    end
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL random_final_count: count=%0d need=0", fifo_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 17; k++) cyc(1'b1, rnd_phv(), 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, '0, 1'b1);
    checks++;
    if (fifo_count !== 5'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: count=%0d ovf=%b (need 7 1)", fifo_count, overflow);
    end
    #3;
    aresetn = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 5'd0 || phv_if.phv_out_valid !== 1'b0 || overflow !== 1'b0 ||
        phv_if.phv_fifo_ready !== 1'b1 || drop_cnt !== 32'd0 || phv_if.phv_out !== '0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b ovf=%b ready=%b drop=%0d (need 0 0 0 1 0)",
               fifo_count, phv_if.phv_out_valid, overflow, phv_if.phv_fifo_ready, drop_cnt);
    end
    mq.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
    cyc(1'b1, PHV_LEN'(8'hAA), 1'b0);
    checks++;
    if (phv_if.phv_out !== PHV_LEN'(8'hAA) || fifo_count !== 5'd1 || phv_if.phv_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_after: out=%0h count=%0d valid=%b (need aa 1 1)",
               phv_if.phv_out[63:0], fifo_count, phv_if.phv_out_valid);
    end
    cyc(1'b0, '0, 1'b1);
    checks++;
    if (fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL async_final: count=%0d need=0", fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_ready_threshold();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phv_rx_fifo.md
Name: phv_rx_fifo

Overview:
- Receiving end of the PHV hand-off from the final pipeline stage. It captures phv_out_0 and phv_out_valid_0 into a buffer and drives phv_fifo_ready_0 back to that stage.
- The last stage registers its output and does not gate valid on ready. Valid PHVs therefore keep arriving for several cycles after ready falls. This block deasserts ready early enough to absorb that in-flight traffic.
- Buffered PHVs are presented first-word-fall-through to the deparser with a valid/ready handshake.

Parameters:
PHV_LEN, 1024, PHV width in bits (48*8+32*8+16*8+256).
DEPTH_LOG2, 4, log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 = 16.
READY_MARGIN, 3, free entries reserved for PHVs already in flight when ready falls.

Ports:
axis_clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
phv_in  in  PHV_LEN  PHV from last stage (phv_out_0)
phv_in_valid  in  1  PHV valid (phv_out_valid_0); not qualified by ready
phv_fifo_ready  out  1  to last stage phv_fifo_ready_0
phv_out  out  PHV_LEN  head PHV to deparser
phv_out_valid  out  1  head valid
phv_out_ready  in  1  deparser accepts head
fifo_count  out  DEPTH_LOG2+1  stored entries, 0..DEPTH
overflow  out  1  sticky: a PHV was dropped because the buffer was full
drop_cnt  out  32  dropped-PHV count (see Optional Feature)

Behaviour:
- Reset: aresetn low clears immediately, without waiting for a clock edge: wr_ptr, rd_ptr, fifo_count=0, overflow=0, drop_cnt=0, phv_out_valid=0.
- While aresetn is low, phv_fifo_ready=1, since it is derived from fifo_count=0.
- Storage array is not reset. phv_out is forced to 0 whenever the buffer is empty.
- Reset asserted mid-operation discards all stored PHVs; no partial state survives.
- Push: phv_in_valid=1 and the buffer is not full → write mem[wr_ptr], wr_ptr+1.
- Push ignores phv_fifo_ready; the upstream stage does not honour ready cycle-accurately.
- Pop: phv_out_valid & phv_out_ready → rd_ptr+1.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH with no special casing.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full and pop in the same cycle: the push is accepted and the count stays at DEPTH; no drop.
- Full and no pop: the incoming PHV is dropped, overflow is set and stays set until reset, and drop_cnt increments if enabled.
- Empty: phv_out_valid=0 and phv_out_ready is ignored. Empty and push in the same cycle: no pop occurs.
- Latency: a PHV pushed at edge N gives phv_out_valid=1 from edge N onward (registered count). That is one cycle of write-to-read latency.
- phv_out = mem[rd_ptr] combinationally. It is stable while phv_out_valid=1 and phv_out_ready=0.
- phv_fifo_ready is combinational from the registered fifo_count: 1 when fifo_count < DEPTH-READY_MARGIN, else 0. Default: ready=0 when count>=13.
- Ordering is strict FIFO; no reordering and no modification of PHV bits. This includes the port-select bits [141+:4].

Optional Feature:
- Macro: PHV_RX_DROP_CNT_EN.
- Defined: drop_cnt is a 32-bit counter incremented on every dropped PHV. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- Not defined: drop_cnt is tied to 0 and no counter logic is built. overflow behaves the same in both builds.

Test Plan:
- Reset, then 5 back-to-back PHVs (values 1..5) with phv_out_ready=1 → deparser sees 1..5 in order, each one cycle after push; fifo_count peaks at 1; phv_fifo_ready stays 1.
- phv_out_ready=0, push 12 PHVs → phv_fifo_ready=1; 13th push → fifo_count=13 and phv_fifo_ready=0 the same cycle the count registers. Push 3 more → count=16, overflow=0.
- Full (16), phv_out_ready=0, push one more → count stays 16, overflow=1, drop_cnt=1 with macro and 0 without. Drain all 16 → original order; dropped PHV absent.
- Full with push and pop in the same cycle → count stays 16, no drop, pushed value emerges as the 16th output.
- Push/pop 40 PHVs with random phv_out_ready (>2 pointer wraps) → output sequence equals input sequence; fifo_count matches the model every cycle.
- Hold 7 PHVs, assert aresetn low between clock edges → outputs clear immediately (count=0, valid=0, overflow=0, phv_fifo_ready=1). After release, new PHV 0xAA is output first.
